nvram_upload_reader: RTL and testbench

Read-side companion to the hiscore NVRAM loader. It serves HPS upload requests for the dump index by pausing the CPU and streaming the game's NVRAM bytes onto `ioctl_din` under `ioctl_wait` flow control. When autosave is enabled and the OSD opens, it checksums the NVRAM and pulses `ioctl_upload_req` only if the contents changed since the last scan. It sits in `emu` between `hps_io` and the shared game NVRAM read port (`hs_address` / `hs_data_out`), alongside `pause`.

---
 rtl/nvram_upload_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_nvram_upload_reader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nvram_upload_reader.sv
// nvram_upload_reader
// Serves HPS uploads of the game NVRAM (pausing the CPU while bytes are read out)
// and, on OSD open with autosave enabled, checksums the NVRAM and requests an
// upload only when the contents changed since the previous scan.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an upload rise (dump index) or an OSD rise
// PWAIT   | pause requested, waiting for the CPU acknowledge
// PAD     | settle cycles after pause acknowledge
// READY   | upload active, accepting ioctl_rd strobes
// FETCH   | NVRAM read latency cycle
// LATCH   | capture NVRAM byte onto ioctl_din, release ioctl_wait
// SCAN    | pipelined walk over the NVRAM accumulating a 16-bit sum
// CMP     | commit the new sum when it differs from the saved one
// RELEASE | pause dropped, back to IDLE next cycle

module nvram_upload_reader #(
  parameter int DUMPWIDTH = 10,
  parameter int DUMPINDEX = 4,
  parameter int PAUSEPAD  = 2
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ioctl_upload,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_rd,
  input  logic [24:0]          ioctl_addr,
  output logic [7:0]           ioctl_din,
  output logic                 ioctl_wait,
  output logic                 ioctl_upload_req,
  output logic [DUMPWIDTH-1:0] nvram_address,
  input  logic [7:0]           nvram_data,
  output logic                 pause_request,
  input  logic                 paused,
  input  logic                 osd_status,
  input  logic                 autosave
);

  typedef enum logic [3:0] {
    IDLE,
    PWAIT,
    PAD,
    READY,
    FETCH,
    LATCH,
    SCAN,
    CMP,
    RELEASE
  } state_t;

  localparam int NBYTES = 1 << DUMPWIDTH;
  // Scan index at which the final byte's data arrives (address pipeline is two deep).
  localparam logic [DUMPWIDTH:0] SCAN_LAST = (DUMPWIDTH + 1)'(NBYTES + 1);
  localparam logic [DUMPWIDTH:0] SCAN_FIRST_DATA = (DUMPWIDTH + 1)'(2);
  // PAD counts down from PAUSEPAD-1 to 0, giving PAUSEPAD cycles in PAD.
  localparam logic [7:0] PAD_LOAD = (PAUSEPAD > 0) ? 8'(PAUSEPAD - 1) : 8'd0;
  localparam logic [7:0] DUMP_IDX = 8'(DUMPINDEX);

  state_t               state;
  logic                 scan_mode;
  logic                 upload_pend;
  logic                 upload_q;
  logic                 osd_q;
  logic [7:0]           pad_cnt;
  logic [DUMPWIDTH:0]   scan_idx;
  logic [15:0]          sum;
  logic [15:0]          saved_sum;

  logic                 upload_rise;
  logic                 upload_fall;
  logic                 osd_rise;
  logic                 index_ok;
  logic                 addr_in_range;
  logic [15:0]          sum_next;

  // Edge detection, index/range decode and the running-sum adder.
  always_comb begin
    upload_rise   = ioctl_upload & ~upload_q;
    upload_fall   = ~ioctl_upload & upload_q;
    osd_rise      = osd_status & ~osd_q;
    index_ok      = (ioctl_index == DUMP_IDX);
    addr_in_range = (ioctl_addr[24:DUMPWIDTH] == '0);
    sum_next      = sum + {8'h00, nvram_data};
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      scan_mode        <= 1'b0;
      upload_pend      <= 1'b0;
      upload_q         <= ioctl_upload;
      osd_q            <= osd_status;
      pad_cnt          <= 8'd0;
      scan_idx         <= '0;
      sum              <= 16'h0000;
      saved_sum        <= 16'h0000;
      ioctl_din        <= 8'h00;
      ioctl_wait       <= 1'b0;
      ioctl_upload_req <= 1'b0;
      nvram_address    <= '0;
      pause_request    <= 1'b0;
    end else begin
      upload_q         <= ioctl_upload;
      osd_q            <= osd_status;
      ioctl_upload_req <= 1'b0;

      // An upload arriving while a scan owns the pause is held off, with
      // ioctl_wait raised immediately so the HPS does not strobe meanwhile.
      if (scan_mode && state != IDLE) begin
        if (upload_rise && index_ok) begin
          upload_pend <= 1'b1;
          ioctl_wait  <= 1'b1;
        end else if (upload_fall) begin
          upload_pend <= 1'b0;
          ioctl_wait  <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if ((upload_pend && ioctl_upload) || (upload_rise && index_ok)) begin
            pause_request <= 1'b1;
            ioctl_wait    <= 1'b1;
            scan_mode     <= 1'b0;
            upload_pend   <= 1'b0;
            state         <= PWAIT;
          end else if (upload_pend) begin
            // The held-off upload ended before it could be served.
            upload_pend <= 1'b0;
            ioctl_wait  <= 1'b0;
          end else if (osd_rise && autosave && !ioctl_upload) begin
            pause_request <= 1'b1;
            sum           <= 16'h0000;
            scan_mode     <= 1'b1;
            state         <= PWAIT;
          end
        end

        PWAIT: begin
          if (!scan_mode && upload_fall) begin
            pause_request <= 1'b0;
            ioctl_wait    <= 1'b0;
            state         <= RELEASE;
          end else if (paused) begin
            pad_cnt <= PAD_LOAD;
            state   <= PAD;
          end
        end

        PAD: begin
          if (!scan_mode && upload_fall) begin
            pause_request <= 1'b0;
            ioctl_wait    <= 1'b0;
            state         <= RELEASE;
          end else if (pad_cnt == 8'd0) begin
            if (scan_mode) begin
              scan_idx <= '0;
              state    <= SCAN;
            end else begin
              ioctl_wait <= 1'b0;
              state      <= READY;
            end
          end else begin
            pad_cnt <= pad_cnt - 8'd1;
          end
        end

        READY: begin
          if (upload_fall) begin
            pause_request <= 1'b0;
            ioctl_wait    <= 1'b0;
            state         <= RELEASE;
          end else if (ioctl_rd) begin
            if (addr_in_range) begin
              nvram_address <= ioctl_addr[DUMPWIDTH-1:0];
              ioctl_wait    <= 1'b1;
              state         <= FETCH;
            end else begin
              ioctl_din <= 8'h00;
            end
          end
        end

        FETCH: begin
          if (upload_fall) begin
            pause_request <= 1'b0;
            ioctl_wait    <= 1'b0;
            state         <= RELEASE;
          end else begin
            state <= LATCH;
          end
        end

        LATCH: begin
          if (upload_fall) begin
            pause_request <= 1'b0;
            ioctl_wait    <= 1'b0;
            state         <= RELEASE;
          end else begin
            ioctl_din  <= nvram_data;
            ioctl_wait <= 1'b0;
            state      <= READY;
          end
        end

        SCAN: begin
          scan_idx <= scan_idx + 1'b1;
          if (!scan_idx[DUMPWIDTH]) begin
            nvram_address <= scan_idx[DUMPWIDTH-1:0];
          end
          if (scan_idx >= SCAN_FIRST_DATA) begin
            sum <= sum_next;
          end
          // The request is registered here so it is high during CMP itself.
          if (scan_idx == SCAN_LAST) begin
            ioctl_upload_req <= (sum_next != saved_sum);
            state            <= CMP;
          end
        end

        CMP: begin
          if (sum != saved_sum) begin
            saved_sum <= sum;
          end
          pause_request <= 1'b0;
          state         <= RELEASE;
        end

        RELEASE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvram_upload_reader.sv
// Directed bench for nvram_upload_reader: pause handshake, read stream from a
// table of address/expected-byte records, autosave change detection, the
// scan/upload collision and reset in the middle of a fetch.

module tb_nvram_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        ioctl_upload_req;
  logic [9:0]  nvram_address;
  logic [7:0]  nvram_data;
  logic        pause_request;
  logic        paused;
  logic        osd_status;
  logic        autosave;

  logic [7:0]  mem [1024];

  int checks_total  = 0;
  int checks_passed = 0;

  nvram_upload_reader #(
    .DUMPWIDTH(10),
    .DUMPINDEX(4),
    .PAUSEPAD (2)
  ) dut (
    .clk_sys         (clk_sys),
    .reset           (reset),
    .ioctl_upload    (ioctl_upload),
    .ioctl_index     (ioctl_index),
    .ioctl_rd        (ioctl_rd),
    .ioctl_addr      (ioctl_addr),
    .ioctl_din       (ioctl_din),
    .ioctl_wait      (ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req),
    .nvram_address   (nvram_address),
    .nvram_data      (nvram_data),
    .pause_request   (pause_request),
    .paused          (paused),
    .osd_status      (osd_status),
    .autosave        (autosave)
  );

  always #5 clk_sys = ~clk_sys;

  // Game RAM model: one cycle read latency.
  always_ff @(posedge clk_sys) nvram_data <= mem[nvram_address];

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  exp_din;
    logic        exp_wait;
  } rd_vec_t;

  rd_vec_t rd_tab [6];

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One ioctl_rd strobe at cycle T, observed at T+1, T+2 and T+3.
  task automatic do_read(input rd_vec_t v, input int idx);
    ioctl_rd   = 1'b1;
    ioctl_addr = v.addr;
    step();
    ioctl_rd = 1'b0;
    chk($sformatf("rd%0d wait T+1", idx), {31'd0, ioctl_wait}, {31'd0, v.exp_wait});
    if (v.exp_wait)
      chk($sformatf("rd%0d nvram_address", idx), {22'd0, nvram_address}, {22'd0, v.addr[9:0]});
    else
      chk($sformatf("rd%0d din T+1", idx), {24'd0, ioctl_din}, 32'h0);
    step();
    chk($sformatf("rd%0d wait T+2", idx), {31'd0, ioctl_wait}, {31'd0, v.exp_wait});
    step();
    chk($sformatf("rd%0d wait T+3", idx), {31'd0, ioctl_wait}, 32'd0);
    chk($sformatf("rd%0d din T+3", idx), {24'd0, ioctl_din}, {24'd0, v.exp_din});
  endtask

  // OSD rise at cycle O; returns the first cycle (relative to O) with the
  // request high, the number of request cycles, and pause_request at O+1031.
  task automatic run_scan(output int first, output int cnt, output logic pause_after);
    first = 0;
    cnt = 0;
    pause_after = 1'b1;
    osd_status = 1'b0;
    step();
    osd_status = 1'b1;
    for (int n = 1; n <= 1045; n++) begin
      step();
      if (ioctl_upload_req) begin
        if (cnt == 0) first = n;
        cnt++;
      end
      if (n == 1031) pause_after = pause_request;
    end
    osd_status = 1'b0;
  endtask

  initial begin
    int   first;
    int   cnt;
    logic pz;

    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[5]     = 8'hA7;
    mem[0]     = 8'h11;
    mem[10'h200] = 8'h3C;
    mem[10'h3FF] = 8'h5C;

    rd_tab[0] = '{addr: 25'h0000005, exp_din: 8'hA7, exp_wait: 1'b1};
    rd_tab[1] = '{addr: 25'h0000400, exp_din: 8'h00, exp_wait: 1'b0};
    rd_tab[2] = '{addr: 25'h00003FF, exp_din: 8'h5C, exp_wait: 1'b1};
    rd_tab[3] = '{addr: 25'h0000000, exp_din: 8'h11, exp_wait: 1'b1};
    rd_tab[4] = '{addr: 25'h1FFFFFF, exp_din: 8'h00, exp_wait: 1'b0};
    rd_tab[5] = '{addr: 25'h0000200, exp_din: 8'h3C, exp_wait: 1'b1};

    reset = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_index = 8'd0;
    ioctl_rd = 1'b0;
    ioctl_addr = '0;
    paused = 1'b0;
    osd_status = 1'b0;
    autosave = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("reset din", {24'd0, ioctl_din}, 32'h0);
    chk("reset wait", {31'd0, ioctl_wait}, 32'h0);
    chk("reset req", {31'd0, ioctl_upload_req}, 32'h0);
    chk("reset pause", {31'd0, pause_request}, 32'h0);
    chk("reset nvaddr", {22'd0, nvram_address}, 32'h0);

    // Wrong index: no response.
    ioctl_index = 8'd3;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("wrong idx pause", {31'd0, pause_request}, 32'h0);
    chk("wrong idx wait", {31'd0, ioctl_wait}, 32'h0);
    ioctl_upload = 1'b0;
    step();

    // OSD rise with autosave off: no scan.
    osd_status = 1'b1;
    step();
    step();
    chk("no autosave pause", {31'd0, pause_request}, 32'h0);
    osd_status = 1'b0;
    step();

    // Upload pause handshake.
    ioctl_index = 8'd4;
    ioctl_upload = 1'b1;
    step();
    chk("hs pause U+1", {31'd0, pause_request}, 32'h1);
    chk("hs wait U+1", {31'd0, ioctl_wait}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hs wait pre-paused %0d", i), {31'd0, ioctl_wait}, 32'h1);
    end
    paused = 1'b1;
    step();
    chk("hs wait P+1", {31'd0, ioctl_wait}, 32'h1);
    step();
    chk("hs wait P+2", {31'd0, ioctl_wait}, 32'h1);
    step();
    chk("hs wait P+3", {31'd0, ioctl_wait}, 32'h0);

    // Read stream from the vector table.
    for (int i = 0; i < 6; i++) do_read(rd_tab[i], i);

    // Upload end releases the pause the next cycle.
    ioctl_upload = 1'b0;
    step();
    chk("end pause", {31'd0, pause_request}, 32'h0);
    chk("end wait", {31'd0, ioctl_wait}, 32'h0);
    step();
    paused = 1'b0;
    step();

    // Autosave change detection.
    for (int i = 0; i < 1024; i++) mem[i] = 8'h01;
    autosave = 1'b1;
    paused = 1'b1;
    run_scan(first, cnt, pz);
    chk("scan1 pulse cycle", first, 1030);
    chk("scan1 pulse count", cnt, 1);
    chk("scan1 pause after CMP", {31'd0, pz}, 32'h0);
    run_scan(first, cnt, pz);
    chk("scan2 pulse count", cnt, 0);
    mem[7] = 8'h02;
    run_scan(first, cnt, pz);
    chk("scan3 pulse cycle", first, 1030);
    chk("scan3 pulse count", cnt, 1);

    // Collision: upload rise mid-scan.
    osd_status = 1'b0;
    step();
    osd_status = 1'b1;
    begin
      int wait_low_bad;
      wait_low_bad = 0;
      for (int n = 1; n <= 1036; n++) begin
        if (n == 100) begin
          ioctl_index = 8'd4;
          ioctl_upload = 1'b1;
        end
        step();
        if (n >= 101 && n <= 1035 && !ioctl_wait) wait_low_bad++;
        if (n == 1031) chk("coll pause RELEASE", {31'd0, pause_request}, 32'h0);
        if (n == 1033) chk("coll pause restart", {31'd0, pause_request}, 32'h1);
        if (n == 1036) chk("coll wait READY", {31'd0, ioctl_wait}, 32'h0);
      end
      chk("coll wait held", wait_low_bad, 0);
    end
    osd_status = 1'b0;
    do_read('{addr: 25'h0000007, exp_din: 8'h02, exp_wait: 1'b1}, 6);

    // Reset during FETCH.
    ioctl_rd = 1'b1;
    ioctl_addr = 25'h5;
    step();
    ioctl_rd = 1'b0;
    chk("fetch nvaddr", {22'd0, nvram_address}, 32'h5);
    reset = 1'b1;
    ioctl_upload = 1'b0;
    step();
    chk("rst din", {24'd0, ioctl_din}, 32'h0);
    chk("rst wait", {31'd0, ioctl_wait}, 32'h0);
    chk("rst pause", {31'd0, pause_request}, 32'h0);
    chk("rst nvaddr", {22'd0, nvram_address}, 32'h0);
    chk("rst req", {31'd0, ioctl_upload_req}, 32'h0);
    reset = 1'b0;
    step();
    run_scan(first, cnt, pz);
    chk("post-rst scan pulse cycle", first, 1030);
    chk("post-rst scan pulse count", cnt, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
